// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//   Turns parallel words into a contiguous serial bit stream for a downstream
//   sequence detector. Words are queued in a 2-entry in-order buffer and shifted
//   out one bit per clock, back-to-back with no idle cycles when the buffer
//   keeps up.
//
// Parameters
//   WIDTH     : bits per input word (2..16)
//   MSB_FIRST : 1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first
//   IDLE_BIT  : level driven on x whenever x_valid is low
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   clr        : synchronous flush of buffer and word in progress
//   din        : parallel word
//   din_valid  : din holds a word
//   din_ready  : a word can be accepted this cycle
//   x          : serial data (registered)
//   x_valid    : x carries a data bit (registered)
//   busy       : shifting or buffer non-empty
//   words_sent : count of fully shifted words, wraps at 256
// -----------------------------------------------------------------------------
module seq_bit_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic [7:0]       words_sent
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [1:0]       count_q, count_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             x_q, x_d;
   logic             xv_q, xv_d;
   logic [7:0]       ws_q, ws_d;
   logic [WIDTH-1:0] buf_q [2];
   logic [WIDTH-1:0] sreg_q;

   logic             last, load, push, pop, wr_idx;

   // Bit that leaves first from a word in shift order.
   function automatic logic pick(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Advance the shift register by one bit in shift order.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   assign din_ready = (count_q < 2'd2) && !clr;
   assign push      = din_valid && din_ready;
   assign last      = (state_q == SHIFT) && (cnt_q == LAST);
   // The head word is taken either from IDLE or on the last bit of the
   // current word, which keeps consecutive words gap-free.
   assign load      = !clr && (count_q != 2'd0) && ((state_q == IDLE) || last);
   assign pop       = load;
   // Pop happens before push within the edge, so a push with a pop lands
   // one slot lower than the current count would suggest.
   assign wr_idx    = (count_q == 2'd1) && !pop;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      xv_d    = xv_q;
      ws_d    = ws_q;
      if (clr) begin
         state_d = IDLE;
         count_d = 2'd0;
         cnt_d   = '0;
         x_d     = IDLE_BIT;
         xv_d    = 1'b0;
      end else begin
         count_d = count_q + 2'(push) - 2'(pop);
         if (last)
            ws_d = ws_q + 8'd1;
         if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            x_d     = pick(buf_q[0]);
            xv_d    = 1'b1;
         end else if (state_q == SHIFT) begin
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
               x_d     = IDLE_BIT;
               xv_d    = 1'b0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               x_d     = pick(advance(sreg_q));
               xv_d    = 1'b1;
            end
         end
      end
   end

   // Control state: state, buffer occupancy, bit counter, outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 2'd0;
         cnt_q   <= '0;
         x_q     <= IDLE_BIT;
         xv_q    <= 1'b0;
         ws_q    <= 8'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         xv_q    <= xv_d;
         ws_q    <= ws_d;
      end
   end

   // Data storage: buffer slots and shift register, qualified by control
   always_ff @(posedge clk) begin
      if (pop)
         buf_q[0] <= buf_q[1];
      if (push)
         buf_q[wr_idx] <= din;
      if (load)
         sreg_q <= buf_q[0];
      else if (state_q == SHIFT)
         sreg_q <= advance(sreg_q);
   end

   assign x          = x_q;
   assign x_valid    = xv_q;
   assign busy       = (state_q == SHIFT) || (count_q != 2'd0);
   assign words_sent = ws_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: two instances share stimulus, one MSB-first
// with idle level 0, one LSB-first with idle level 1, each tracked by a
// word/bit-level reference model.
module tb_seq_bit_serializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         clr = 1'b0;
   logic         din_valid = 1'b0;
   logic [W-1:0] din = '0;

   logic         a_rdy, a_x, a_xv, a_busy;
   logic [7:0]   a_ws;
   logic         b_rdy, b_x, b_xv, b_busy;
   logic [7:0]   b_ws;

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
      .din_ready(a_rdy), .x(a_x), .x_valid(a_xv), .busy(a_busy),
      .words_sent(a_ws));

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .din(din), .din_valid(din_valid),
      .din_ready(b_rdy), .x(b_x), .x_valid(b_xv), .busy(b_busy),
      .words_sent(b_ws));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: per instance, a list of buffered words, the word being
   // emitted and how many of its bits are still to be shown.
   logic [W-1:0] mq [2][2];
   int           mn [2];
   logic [W-1:0] mw [2];
   int           ml [2];
   int           mws[2];

   // Serial capture of each stream while x_valid is high; first bit ends up
   // most significant.
   logic [31:0]  cola, colb;

   function automatic logic idle_of(input int m);
      return (m == 1);
   endfunction

   function automatic logic exp_x(input int m);
      int pos;
      if (ml[m] == 0) return idle_of(m);
      pos = W - ml[m];
      return (m == 0) ? mw[m][W-1-pos] : mw[m][pos];
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mn[m] = 0; ml[m] = 0; mws[m] = 0;
      end
   endtask

   task automatic model_edge(input logic v, input logic c, input logic [W-1:0] d);
      for (int m = 0; m < 2; m++) begin
         logic pushm;
         pushm = v && (mn[m] < 2) && !c;
         if (c) begin
            mn[m] = 0;
            ml[m] = 0;
         end else begin
            if (ml[m] > 0) begin
               ml[m]--;
               if (ml[m] == 0) mws[m] = (mws[m] + 1) % 256;
            end
            if (ml[m] == 0 && mn[m] > 0) begin
               mw[m]    = mq[m][0];
               mq[m][0] = mq[m][1];
               mn[m]--;
               ml[m]    = W;
            end
            if (pushm) begin
               mq[m][mn[m]] = d;
               mn[m]++;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("a_ready", a_rdy,  (mn[0] < 2) && !clr);
      chk("a_xv",    a_xv,   ml[0] > 0);
      chk("a_x",     a_x,    exp_x(0));
      chk("a_busy",  a_busy, (ml[0] > 0) || (mn[0] > 0));
      chk("a_ws",    a_ws,   mws[0]);
      chk("b_ready", b_rdy,  (mn[1] < 2) && !clr);
      chk("b_xv",    b_xv,   ml[1] > 0);
      chk("b_x",     b_x,    exp_x(1));
      chk("b_busy",  b_busy, (ml[1] > 0) || (mn[1] > 0));
      chk("b_ws",    b_ws,   mws[1]);
      if (a_xv) cola = {cola[30:0], a_x};
      if (b_xv) colb = {colb[30:0], b_x};
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_edge(din_valid, clr, din);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_a_x"},    a_x,    1'b0);
      chk({tag, "_a_xv"},   a_xv,   1'b0);
      chk({tag, "_a_busy"}, a_busy, 1'b0);
      chk({tag, "_a_ws"},   a_ws,   8'd0);
      chk({tag, "_a_rdy"},  a_rdy,  1'b1);
      chk({tag, "_b_x"},    b_x,    1'b1);
      chk({tag, "_b_xv"},   b_xv,   1'b0);
      chk({tag, "_b_busy"}, b_busy, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din_valid = 1'b0;
      clr = 1'b0;
      #1;
      check_reset_values("rst");
      model_reset();
      @(posedge clk);
      #1;
      check_reset_values("rst_hold");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int sent;
      bit saw_full;
      logic [W-1:0] words [4];
      logic [7:0] ws_before;

      model_reset();
      #2;
      do_reset();

      // Single word from idle, both bit orders.
      cola = '0; colb = '0;
      din = 4'b1011; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("single_msb_bits", cola, 32'b1011);
      chk("single_lsb_bits", colb, 32'b1101);
      chk("single_ws", a_ws, 8'd1);
      chk("single_idle_x", a_x, 1'b0);

      // Two words back-to-back: eight contiguous bits.
      cola = '0;
      din = 4'b1011; din_valid = 1'b1;
      step();
      din = 4'b0110;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("b2b_bits", cola, 32'b10110110);
      chk("b2b_ws", a_ws, 8'd3);

      // Hold din_valid for four words; the buffer fills and backpressures.
      cola = '0;
      words = '{4'b1001, 4'b0111, 4'b1100, 4'b0101};
      sent = 0;
      saw_full = 1'b0;
      while (sent < 4) begin
         logic rdy_now;
         din = words[sent];
         din_valid = 1'b1;
         rdy_now = a_rdy;
         if (!rdy_now) saw_full = 1'b1;
         step();
         if (rdy_now) sent++;
      end
      din_valid = 1'b0;
      for (int i = 0; i < 16; i++) step();
      chk("hold_backpressure", saw_full, 1'b1);
      chk("hold_bits", cola, 32'h97C5);
      chk("hold_ws", a_ws, 8'd7);

      // Flush on the second bit of a word while one word is buffered.
      ws_before = a_ws;
      din = 4'b1110; din_valid = 1'b1;
      step();
      din = 4'b0011;
      step();
      din_valid = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_xv", a_xv, 1'b0);
      chk("clr_busy", a_busy, 1'b0);
      chk("clr_ws", a_ws, ws_before);
      for (int i = 0; i < 3; i++) step();

      // Asynchronous reset between edges in the middle of a word.
      din = 4'b1111; din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      step();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         din_valid = ($urandom_range(0, 3) != 0);
         din = W'($urandom);
         clr = ($urandom_range(0, 29) == 0);
         step();
      end
      clr = 1'b0;
      din_valid = 1'b0;
      for (int i = 0; i < 12; i++) step();

      // 256 words from reset: the counter wraps back to zero.
      do_reset();
      sent = 0;
      while (sent < 256) begin
         logic rdy_now;
         din = W'($urandom);
         din_valid = 1'b1;
         rdy_now = a_rdy;
         step();
         if (rdy_now) sent++;
      end
      din_valid = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("wrap_ws_a", a_ws, 8'd0);
      chk("wrap_ws_b", b_ws, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/seq_bit_serializer.md
SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the bits per input word (legal range 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 out first, 0 shifts bit 0 first.
REQ-003 SHALL have parameter IDLE_BIT, default 0, giving the value driven on x when no word is being shifted.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port clr, input, 1 bit: synchronous flush.
REQ-007 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-008 SHALL have port din_valid, input, 1 bit: din holds a word.
REQ-009 SHALL have port din_ready, output, 1 bit: block can accept a word this cycle.
REQ-010 SHALL have port x, output, 1 bit: serial bit stream for the downstream sequence detector input.
REQ-011 SHALL have port x_valid, output, 1 bit: x carries a data bit this cycle.
REQ-012 SHALL have port busy, output, 1 bit: high when the state machine is in SHIFT or the buffer holds any word.
REQ-013 SHALL have port words_sent, output, 8 bits: count of fully shifted words.

Function
REQ-014 SHALL hold a 2-entry in-order word buffer; din_ready SHALL equal (buffer count < 2) AND NOT clr, combinationally.
REQ-015 SHALL accept a word on a rising edge where din_valid and din_ready are both 1; there is no bypass path.
REQ-016 SHALL use a state machine with two states: IDLE and SHIFT.
REQ-017 IDLE, buffer non-empty: SHALL load the head word into the shift register, pop it, set bit counter to 0 and enter SHIFT in the same edge.
REQ-018 x and x_valid SHALL be registered; a word accepted into an empty buffer in IDLE at edge k SHALL present its first bit, with x_valid=1, from edge k+1 (when k+1 is the loading edge).
REQ-019 SHIFT: each edge SHALL present the next bit (per MSB_FIRST) and increment the bit counter; each word occupies exactly WIDTH consecutive x_valid cycles.
REQ-020 Last bit (counter = WIDTH-1), buffer non-empty: SHALL load the next word on the same edge, so there are zero idle cycles between words.
REQ-021 Last bit, buffer empty: SHALL return to IDLE, drive x_valid=0 and x=IDLE_BIT.
REQ-022 Simultaneous push and pop SHALL leave the buffer count unchanged and preserve order.
REQ-023 Count=2 SHALL hold din_ready=0; no word is dropped or overwritten.
REQ-024 words_sent SHALL increment by 1 on the edge that completes a word's last bit and wrap from 255 to 0.
REQ-025 clr=1 at an edge SHALL empty the buffer, abort any word in progress and enter IDLE with x_valid=0 and x=IDLE_BIT; words_sent is unchanged; clr overrides a simultaneous push.
REQ-026 When x_valid=0, x SHALL always equal IDLE_BIT.

Reset
REQ-027 While rst=1, regardless of clk: state=IDLE, buffer empty, x=IDLE_BIT, x_valid=0, busy=0, words_sent=0, bit counter=0.
REQ-028 din_ready SHALL be 1 during and immediately after reset when clr=0.
REQ-029 rst asserted mid-word SHALL discard the word in progress and all buffered words immediately, with no partial completion counted.

Verification (WIDTH=4, MSB_FIRST=1, IDLE_BIT=0)
REQ-030 Push 4'b1011 once from idle -> x=1,0,1,1 on 4 consecutive x_valid cycles starting 1 cycle after acceptance; then x_valid=0, x=0; words_sent=1.
REQ-031 Push 4'b1011 and 4'b0110 back-to-back -> 8 contiguous x_valid cycles: 1,0,1,1,0,1,1,0; words_sent=2.
REQ-032 Hold din_valid=1 for 4 words while shifting -> din_ready drops once 2 are buffered; all 4 words are emitted in order with no gaps.
REQ-033 Assert clr on the 2nd bit of a word with 1 word buffered -> next cycle x_valid=0, busy=0, words_sent unchanged.
REQ-034 Assert rst asynchronously mid-word (between clock edges) -> outputs take reset values immediately, before the next clock edge.
REQ-035 Send 256 words -> words_sent wraps to 0; with MSB_FIRST=0, 4'b1011 is emitted as 1,1,0,1.
